// File: rtl/lisp_pkg.sv
// Shared Lisp definitions: cell type tags, allocator FSM states and cell sizing.
package lisp;

    localparam int unsigned addr_width = 16;
    localparam int unsigned data_width = 16;

    // Cell type tags, stored as the first word of every heap cell
    localparam logic [data_width-1:0] TYPE_NUMBER    = 16'h0001;
    localparam logic [data_width-1:0] TYPE_CONS      = 16'h0002;
    localparam logic [data_width-1:0] TYPE_FUNC_PRIM = 16'h0003;
    localparam logic [data_width-1:0] TYPE_FUNC      = 16'h0004;

    typedef enum logic [2:0] {
        StIdle,
        StWTag,
        StWF0,
        StWF1,
        StWF2,
        StDone,
        StErr
    } alloc_state_t;

    // Cell size in words, including the tag word; 0 marks an illegal tag
    function automatic logic [2:0] cell_size(input logic [data_width-1:0] tag);
        logic [2:0] size;
        case (tag)
            TYPE_NUMBER, TYPE_FUNC_PRIM: size = 3'd2;
            TYPE_CONS:                   size = 3'd3;
            TYPE_FUNC:                   size = 3'd4;
            default:                     size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/cell_allocator.sv
// Bump-pointer heap allocator: writes a tagged Lisp cell word by word through the
// memory controller write port and reports the cell base address.
// Optional heap bounds check enabled by defining CELL_ALLOC_BOUNDS_EN; without it the
// free pointer and write addresses wrap modulo 2^ADDR_WIDTH.
module cell_allocator
    import lisp::*;
#(
    parameter int unsigned            ADDR_WIDTH = 16,
    parameter int unsigned            DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  HEAP_BASE  = 16'h0100,
    parameter logic [ADDR_WIDTH-1:0]  HEAP_LIMIT = 16'hFFFF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req,
    output logic                  alloc_ready,
    input  logic [DATA_WIDTH-1:0] alloc_tag,
    input  logic [DATA_WIDTH-1:0] alloc_f0,
    input  logic [DATA_WIDTH-1:0] alloc_f1,
    input  logic [DATA_WIDTH-1:0] alloc_f2,
    output logic                  alloc_done,
    output logic [ADDR_WIDTH-1:0] alloc_addr,
    output logic                  alloc_error,
    output logic [ADDR_WIDTH-1:0] heap_ptr,
    input  logic                  mem_busy,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata
);

`ifdef CELL_ALLOC_BOUNDS_EN
    localparam bit BoundsEn = 1'b1;
`else
    localparam bit BoundsEn = 1'b0;
`endif

    alloc_state_t          state_q;
    logic [DATA_WIDTH-1:0] f0_q, f1_q, f2_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [2:0]            size_q;
    logic [ADDR_WIDTH-1:0] heap_ptr_q;
    logic [ADDR_WIDTH-1:0] alloc_addr_q;
    logic                  done_q;
    logic                  error_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [DATA_WIDTH-1:0] mem_wdata_q;

    logic [2:0]            size_new;
    logic [ADDR_WIDTH:0]   sum_new;
    logic [ADDR_WIDTH:0]   limit_end;
    logic                  bounds_fail;
    logic [2:0]            cur_off;
    logic [2:0]            nxt_off;
    logic                  last_word;
    logic [ADDR_WIDTH-1:0] nxt_addr;
    logic [DATA_WIDTH-1:0] nxt_word;
    logic [ADDR_WIDTH-1:0] end_ptr;
    alloc_state_t          adv_state;

    // Accept-cycle sizing/bounds and write-state sequencing helpers
    always_comb begin
        size_new    = cell_size(data_width'(alloc_tag));
        // Extra top bit keeps the end address exact for the bounds compare
        sum_new     = {1'b0, heap_ptr_q} + (ADDR_WIDTH + 1)'(size_new);
        limit_end   = {1'b0, HEAP_LIMIT} + (ADDR_WIDTH + 1)'(1);
        bounds_fail = BoundsEn && (sum_new > limit_end);

        cur_off   = 3'd0;
        adv_state = StDone;
        case (state_q)
            StWTag:  begin cur_off = 3'd0; adv_state = StWF0;  end
            StWF0:   begin cur_off = 3'd1; adv_state = StWF1;  end
            StWF1:   begin cur_off = 3'd2; adv_state = StWF2;  end
            StWF2:   begin cur_off = 3'd3; adv_state = StDone; end
            default: begin cur_off = 3'd0; adv_state = StDone; end
        endcase
        nxt_off   = cur_off + 3'd1;
        last_word = (nxt_off == size_q);
        nxt_addr  = base_q + ADDR_WIDTH'(nxt_off);
        end_ptr   = base_q + ADDR_WIDTH'(size_q);

        case (nxt_off)
            3'd1:    nxt_word = f0_q;
            3'd2:    nxt_word = f1_q;
            default: nxt_word = f2_q;
        endcase
    end

    // Allocator FSM with registered outputs and free pointer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            f0_q         <= '0;
            f1_q         <= '0;
            f2_q         <= '0;
            base_q       <= '0;
            size_q       <= '0;
            heap_ptr_q   <= HEAP_BASE;
            alloc_addr_q <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            we_q         <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (alloc_req) begin
                        f0_q   <= alloc_f0;
                        f1_q   <= alloc_f1;
                        f2_q   <= alloc_f2;
                        base_q <= heap_ptr_q;
                        size_q <= size_new;
                        if (size_new == 3'd0 || bounds_fail) begin
                            state_q <= StErr;
                            error_q <= 1'b1;
                        end else begin
                            // The tag word goes straight into the write data register
                            state_q     <= StWTag;
                            we_q        <= 1'b1;
                            mem_addr_q  <= heap_ptr_q;
                            mem_wdata_q <= alloc_tag;
                        end
                    end
                end
                StWTag, StWF0, StWF1, StWF2: begin
                    if (!mem_busy) begin
                        if (last_word) begin
                            state_q      <= StDone;
                            we_q         <= 1'b0;
                            done_q       <= 1'b1;
                            alloc_addr_q <= base_q;
                            heap_ptr_q   <= end_ptr;
                        end else begin
                            state_q     <= adv_state;
                            mem_addr_q  <= nxt_addr;
                            mem_wdata_q <= nxt_word;
                        end
                    end
                end
                StDone:  state_q <= StIdle;
                StErr:   state_q <= StErr;
                default: state_q <= StIdle;
            endcase
        end
    end

    // A busy controller suppresses the strobe; address/data stay put for the retry
    assign mem_we      = we_q & ~mem_busy;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign alloc_ready = (state_q == StIdle);
    assign alloc_done  = done_q;
    assign alloc_addr  = alloc_addr_q;
    assign alloc_error = error_q;
    assign heap_ptr    = heap_ptr_q;

endmodule

// File: tb/tb_cell_allocator.sv
// Directed bench for cell_allocator: a per-cycle vector table on a default-limit
// instance, plus a hand-written heap-limit sequence on a second, small-limit instance.
module tb_cell_allocator;
    import lisp::*;

    localparam logic [15:0] N = TYPE_NUMBER;
    localparam logic [15:0] C = TYPE_CONS;
    localparam logic [15:0] P = TYPE_FUNC_PRIM;
    localparam logic [15:0] F = TYPE_FUNC;
    localparam logic [15:0] Z = 16'h0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, req = 1'b0, busy = 1'b0;
    logic [15:0] tag = '0, f0 = '0, f1 = '0, f2 = '0;

    logic        a_ready, a_done, a_err, a_we;
    logic [15:0] a_aaddr, a_ptr, a_maddr, a_wdata;
    logic        b_ready, b_done, b_err, b_we;
    logic [15:0] b_aaddr, b_ptr, b_maddr, b_wdata;

    always #5 clk = ~clk;

    cell_allocator #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .HEAP_BASE(16'h0100),
                     .HEAP_LIMIT(16'hFFFF)) dut_a (
        .clk(clk), .rst_n(rst_n), .alloc_req(req), .alloc_ready(a_ready),
        .alloc_tag(tag), .alloc_f0(f0), .alloc_f1(f1), .alloc_f2(f2),
        .alloc_done(a_done), .alloc_addr(a_aaddr), .alloc_error(a_err),
        .heap_ptr(a_ptr), .mem_busy(busy), .mem_we(a_we), .mem_addr(a_maddr),
        .mem_wdata(a_wdata)
    );

    cell_allocator #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .HEAP_BASE(16'h0100),
                     .HEAP_LIMIT(16'h0103)) dut_b (
        .clk(clk), .rst_n(rst_n), .alloc_req(req), .alloc_ready(b_ready),
        .alloc_tag(tag), .alloc_f0(f0), .alloc_f1(f1), .alloc_f2(f2),
        .alloc_done(b_done), .alloc_addr(b_aaddr), .alloc_error(b_err),
        .heap_ptr(b_ptr), .mem_busy(busy), .mem_we(b_we), .mem_addr(b_maddr),
        .mem_wdata(b_wdata)
    );

    typedef struct {
        logic        rst_n, req, busy;
        logic [15:0] tag, f0, f1, f2;
        logic        chk, ready, we, done, err, chk_mem;
        logic [15:0] maddr, wdata, aaddr, ptr;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad = 0;
    int   row = 0;

    task automatic cmp1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %b want %b", name, row, act, exp);
        end
    endtask

    task automatic cmp16(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h want %h", name, row, act, exp);
        end
    endtask

    // One table row = one clock cycle: inputs for that cycle, then expected outputs
    task automatic in_(input logic r, input logic q, input logic b, input logic [15:0] t,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        vec_t v;
        v = '{default: '0};
        v.rst_n = r; v.req = q; v.busy = b;
        v.tag = t; v.f0 = a0; v.f1 = a1; v.f2 = a2;
        vecs.push_back(v);
    endtask

    task automatic ex(input logic rdy, input logic we, input logic dn, input logic er,
                      input logic [15:0] aa, input logic [15:0] pt);
        int k = vecs.size() - 1;
        vecs[k].chk = 1'b1; vecs[k].ready = rdy; vecs[k].we = we;
        vecs[k].done = dn; vecs[k].err = er; vecs[k].aaddr = aa; vecs[k].ptr = pt;
    endtask

    task automatic em(input logic [15:0] ma, input logic [15:0] wd);
        int k = vecs.size() - 1;
        vecs[k].chk_mem = 1'b1; vecs[k].maddr = ma; vecs[k].wdata = wd;
    endtask

    task automatic cyc(input logic r, input logic q, input logic b, input logic [15:0] t,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        @(negedge clk);
        rst_n = r; req = q; busy = b; tag = t; f0 = a0; f1 = a1; f2 = a2;
        #1;
    endtask

    initial begin
        // Reset values
        in_(0, 0, 0, Z, Z, Z, Z);
        in_(1, 0, 0, Z, Z, Z, Z); ex(1, 0, 0, 0, Z, 16'h0100); em(Z, Z);
        // Single NUMBER
        in_(1, 1, 0, N, 16'h002A, Z, Z); ex(1, 0, 0, 0, Z, 16'h0100);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0100, N);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0101, 16'h002A);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 0, 1, 0, 16'h0100, 16'h0102);
        in_(1, 0, 0, Z, Z, Z, Z); ex(1, 0, 0, 0, 16'h0100, 16'h0102);
        // CONS then FUNC with request held high
        in_(0, 0, 0, Z, Z, Z, Z);
        in_(1, 1, 0, C, 16'h1111, 16'h2222, Z); ex(1, 0, 0, 0, Z, 16'h0100);
        in_(1, 1, 0, F, 16'hAAAA, 16'hBBBB, 16'hCCCC); ex(0, 1, 0, 0, Z, 16'h0100);
        em(16'h0100, C);
        in_(1, 1, 0, F, 16'hAAAA, 16'hBBBB, 16'hCCCC); ex(0, 1, 0, 0, Z, 16'h0100);
        em(16'h0101, 16'h1111);
        in_(1, 1, 0, F, 16'hAAAA, 16'hBBBB, 16'hCCCC); ex(0, 1, 0, 0, Z, 16'h0100);
        em(16'h0102, 16'h2222);
        in_(1, 1, 0, F, 16'hAAAA, 16'hBBBB, 16'hCCCC); ex(0, 0, 1, 0, 16'h0100, 16'h0103);
        in_(1, 1, 0, F, 16'hAAAA, 16'hBBBB, 16'hCCCC); ex(1, 0, 0, 0, 16'h0100, 16'h0103);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, 16'h0100, 16'h0103); em(16'h0103, F);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, 16'h0100, 16'h0103); em(16'h0104, 16'hAAAA);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, 16'h0100, 16'h0103); em(16'h0105, 16'hBBBB);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, 16'h0100, 16'h0103); em(16'h0106, 16'hCCCC);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 0, 1, 0, 16'h0103, 16'h0107);
        in_(1, 0, 0, Z, Z, Z, Z); ex(1, 0, 0, 0, 16'h0103, 16'h0107);
        // Two busy cycles in W_F0 of a CONS
        in_(0, 0, 0, Z, Z, Z, Z);
        in_(1, 1, 0, C, 16'h3333, 16'h4444, Z); ex(1, 0, 0, 0, Z, 16'h0100);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0100, C);
        in_(1, 0, 1, Z, Z, Z, Z); ex(0, 0, 0, 0, Z, 16'h0100); em(16'h0101, 16'h3333);
        in_(1, 0, 1, Z, Z, Z, Z); ex(0, 0, 0, 0, Z, 16'h0100); em(16'h0101, 16'h3333);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0101, 16'h3333);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0102, 16'h4444);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 0, 1, 0, 16'h0100, 16'h0103);
        // Illegal tag: terminal error, no writes
        in_(0, 0, 0, Z, Z, Z, Z);
        in_(1, 1, 0, 16'hBEEF, Z, Z, Z); ex(1, 0, 0, 0, Z, 16'h0100);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 0, 0, 1, Z, 16'h0100);
        in_(1, 1, 0, N, 16'h0001, Z, Z); ex(0, 0, 0, 1, Z, 16'h0100);
        in_(1, 1, 0, N, 16'h0001, Z, Z); ex(0, 0, 0, 1, Z, 16'h0100);
        // Reset during W_F1 of a FUNC
        in_(0, 0, 0, Z, Z, Z, Z);
        in_(1, 1, 0, F, 16'h0011, 16'h0022, 16'h0033); ex(1, 0, 0, 0, Z, 16'h0100);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0100, F);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0101, 16'h0011);
        in_(0, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0102, 16'h0022);
        in_(1, 0, 0, Z, Z, Z, Z); ex(1, 0, 0, 0, Z, 16'h0100); em(Z, Z);
        // FUNC_PRIM after the abandoned cell reuses the base address
        in_(1, 1, 0, P, 16'h5555, Z, Z); ex(1, 0, 0, 0, Z, 16'h0100);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0100, P);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 1, 0, 0, Z, 16'h0100); em(16'h0101, 16'h5555);
        in_(1, 0, 0, Z, Z, Z, Z); ex(0, 0, 1, 0, 16'h0100, 16'h0102);
        in_(1, 0, 0, Z, Z, Z, Z); ex(1, 0, 0, 0, 16'h0100, 16'h0102);

        foreach (vecs[i]) begin
            row = i;
            cyc(vecs[i].rst_n, vecs[i].req, vecs[i].busy, vecs[i].tag,
                vecs[i].f0, vecs[i].f1, vecs[i].f2);
            if (vecs[i].chk) begin
                cmp1("ready", a_ready, vecs[i].ready);
                cmp1("mem_we", a_we, vecs[i].we);
                cmp1("done", a_done, vecs[i].done);
                cmp1("error", a_err, vecs[i].err);
                cmp16("alloc_addr", a_aaddr, vecs[i].aaddr);
                cmp16("heap_ptr", a_ptr, vecs[i].ptr);
            end
            if (vecs[i].chk_mem) begin
                cmp16("mem_addr", a_maddr, vecs[i].maddr);
                cmp16("mem_wdata", a_wdata, vecs[i].wdata);
            end
        end

        // Heap limit 0x0103: CONS fills 0x0100..0x0102, then a NUMBER at 0x0103
        row = 1000;
        cyc(0, 0, 0, Z, Z, Z, Z);
        cyc(1, 1, 0, C, 16'h7777, 16'h8888, Z);
        cmp1("b_ready", b_ready, 1'b1);
        cyc(1, 0, 0, Z, Z, Z, Z);
        cyc(1, 0, 0, Z, Z, Z, Z);
        cyc(1, 0, 0, Z, Z, Z, Z);
        cmp16("b_mem_addr", b_maddr, 16'h0102);
        cyc(1, 0, 0, Z, Z, Z, Z);
        cmp1("b_done", b_done, 1'b1);
        cmp16("b_alloc_addr", b_aaddr, 16'h0100);
        cmp16("b_heap_ptr", b_ptr, 16'h0103);
        cyc(1, 1, 0, N, 16'h9999, Z, Z);
        cmp1("b_ready_2", b_ready, 1'b1);
        cmp1("b_error_pre", b_err, 1'b0);
        cyc(1, 0, 0, Z, Z, Z, Z);
`ifdef CELL_ALLOC_BOUNDS_EN
        cmp1("b_error", b_err, 1'b1);
        cmp1("b_mem_we", b_we, 1'b0);
        cmp16("b_heap_ptr_err", b_ptr, 16'h0103);
        cyc(1, 0, 0, Z, Z, Z, Z);
        cmp1("b_mem_we_2", b_we, 1'b0);
        cmp1("b_ready_err", b_ready, 1'b0);
        cmp16("b_heap_ptr_err2", b_ptr, 16'h0103);
`else
        cmp1("b_error", b_err, 1'b0);
        cmp1("b_mem_we", b_we, 1'b1);
        cmp16("b_mem_addr_tag", b_maddr, 16'h0103);
        cmp16("b_mem_wdata_tag", b_wdata, N);
        cyc(1, 0, 0, Z, Z, Z, Z);
        cmp1("b_mem_we_2", b_we, 1'b1);
        cmp16("b_mem_addr_f0", b_maddr, 16'h0104);
        cmp16("b_mem_wdata_f0", b_wdata, 16'h9999);
        cyc(1, 0, 0, Z, Z, Z, Z);
        cmp1("b_done_2", b_done, 1'b1);
        cmp16("b_heap_ptr_end", b_ptr, 16'h0105);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
